// File: rtl/pll_pkg.sv
// +--------------------------------------------------------------------+
// | pll_pkg: state encodings and default timing for the PLL sequencer  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package pll_pkg;

  typedef logic [2:0] pll_state_t;

  localparam pll_state_t ST_PLL_RST   = 3'd0;
  localparam pll_state_t ST_WAIT_LOCK = 3'd1;
  localparam pll_state_t ST_QUALIFY   = 3'd2;
  localparam pll_state_t ST_RUN       = 3'd3;
  localparam pll_state_t ST_LOST      = 3'd4;

  localparam int unsigned PLL_RST_CYCLES_DEF      = 16;
  localparam int unsigned LOCK_QUAL_CYCLES_DEF    = 1024;
  localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF = 1200000;
  localparam int unsigned LOSS_CNT_W_DEF          = 8;
  localparam int unsigned SEQ_CNT_W               = 24;

endpackage

`default_nettype wire

// File: rtl/pll_lock_sequencer_if.sv
// +--------------------------------------------------------------------+
// | pll_lock_sequencer_if: PLL control/status bundle of the sequencer  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

interface pll_lock_sequencer_if #(
  parameter int unsigned LOSS_CNT_W = 8
);

  logic                  lock;
  logic                  pll_resetb;
  logic                  run_resetb;
  logic                  ready;
  logic [2:0]            state_o;
  logic [LOSS_CNT_W-1:0] loss_count;
  logic [LOSS_CNT_W-1:0] timeout_count;

  modport master (
    input  lock,
    output pll_resetb,
    output run_resetb,
    output ready,
    output state_o,
    output loss_count,
    output timeout_count
  );

  modport slave (
    output lock,
    input  pll_resetb,
    input  run_resetb,
    input  ready,
    input  state_o,
    input  loss_count,
    input  timeout_count
  );

endinterface

`default_nettype wire

// File: rtl/sync_2ff.sv
// +--------------------------------------------------------------------+
// | sync_2ff: two-flop synchronizer for a single asynchronous input    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module sync_2ff (
  input  wire logic clk,
  input  wire logic resetb,
  input  wire logic d,
  output logic      q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
// +--------------------------------------------------------------------+
// | pll_lock_sequencer: PLL reset/lock qualification and run release   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module pll_lock_sequencer
  import pll_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = PLL_RST_CYCLES_DEF,
  parameter int unsigned LOCK_QUAL_CYCLES    = LOCK_QUAL_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
  parameter int unsigned LOSS_CNT_W          = LOSS_CNT_W_DEF
) (
  input  wire logic            clk,
  input  wire logic            resetb,
  pll_lock_sequencer_if.master bus
);

  localparam logic [SEQ_CNT_W-1:0]  c_RST_LAST  = SEQ_CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [SEQ_CNT_W-1:0]  c_QUAL_LAST = SEQ_CNT_W'(LOCK_QUAL_CYCLES - 1);
  localparam logic [SEQ_CNT_W-1:0]  c_TO_LAST   = SEQ_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [LOSS_CNT_W-1:0] c_EVT_MAX   = '1;

  logic                  w_lock_s;
  pll_state_t            r_state;
  pll_state_t            w_next;
  logic [SEQ_CNT_W-1:0]  r_cnt;
  logic                  w_cnt_en;
  logic                  w_timeout_evt;
  logic                  w_loss_evt;
  logic                  w_pll_resetb_d;
  logic                  w_run_d;
  logic                  r_pll_resetb;
  logic                  r_run;
  logic [LOSS_CNT_W-1:0] r_loss_count;
  logic [LOSS_CNT_W-1:0] r_timeout_count;

  sync_2ff u_lock_sync (
    .clk    (clk),
    .resetb (resetb),
    .d      (bus.lock),
    .q      (w_lock_s)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state <= ST_PLL_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Lock is checked before the timeout so a lock on the terminal cycle wins.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_PLL_RST: begin
        if (r_cnt == c_RST_LAST) w_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s)                w_next = ST_QUALIFY;
        else if (r_cnt == c_TO_LAST) w_next = ST_PLL_RST;
      end
      ST_QUALIFY: begin
        if (!w_lock_s)                 w_next = ST_WAIT_LOCK;
        else if (r_cnt == c_QUAL_LAST) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (!w_lock_s) w_next = ST_LOST;
      end
      ST_LOST: begin
        w_next = ST_PLL_RST;
      end
      default: begin
        w_next = ST_PLL_RST;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state register and never glitch.
  always_comb begin
    w_pll_resetb_d = 1'b1;
    w_run_d        = 1'b0;
    w_timeout_evt  = 1'b0;
    w_loss_evt     = 1'b0;
    w_cnt_en       = 1'b0;
    if (w_next == ST_PLL_RST) w_pll_resetb_d = 1'b0;
    if (w_next == ST_RUN)     w_run_d        = 1'b1;
    if ((r_state == ST_WAIT_LOCK) && (w_next == ST_PLL_RST)) w_timeout_evt = 1'b1;
    if ((r_state == ST_RUN) && (w_next == ST_LOST))          w_loss_evt    = 1'b1;
    if ((r_state == ST_PLL_RST) || (r_state == ST_WAIT_LOCK) || (r_state == ST_QUALIFY))
      w_cnt_en = 1'b1;
  end

  // The counter idles in RUN so it cannot wrap during a long lock.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (w_cnt_en) begin
      r_cnt <= r_cnt + SEQ_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_pll_resetb    <= 1'b0;
      r_run           <= 1'b0;
      r_loss_count    <= '0;
      r_timeout_count <= '0;
    end else begin
      r_pll_resetb <= w_pll_resetb_d;
      r_run        <= w_run_d;
      if (w_loss_evt && (r_loss_count != c_EVT_MAX))
        r_loss_count <= r_loss_count + LOSS_CNT_W'(1);
      if (w_timeout_evt && (r_timeout_count != c_EVT_MAX))
        r_timeout_count <= r_timeout_count + LOSS_CNT_W'(1);
    end
  end

  assign bus.pll_resetb    = r_pll_resetb;
  assign bus.run_resetb    = r_run;
  assign bus.ready         = r_run;
  assign bus.state_o       = r_state;
  assign bus.loss_count    = r_loss_count;
  assign bus.timeout_count = r_timeout_count;

endmodule

`default_nettype wire
